// File: rtl/jtcontra_gfx_linebuf.sv
// Double-buffered 2x512x9 line store: renderer writes one half, scanner reads
// and erases the other half at pixel rate.
module jtcontra_gfx_linebuf #(
  parameter logic [8:0] CLR_VAL = 9'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic [8:0] hdump,
  input  logic       line,
  input  logic       done,
  input  logic       txt_line,
  input  logic       scr_we,
  input  logic [9:0] line_addr,
  input  logic [8:0] line_din,
  output logic [8:0] pxl_out,
  output logic       pxl_txt,
  output logic       ovr,
  output logic       busy
);

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 9;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] ERASE = 2'd2;

  logic [1:0]    state, state_nx;
  logic [AW-1:0] rd_addr, clr_cnt, b_addr;
  logic [DW-1:0] q;
  logic          swept, line_l, b_we, b_re;
  logic [DW-1:0] mem [0:DEPTH-1];

  // Scan next-state and port B control; the clear sweep owns port B while busy
  always_comb begin
    state_nx = state;
    b_we     = 1'b0;
    b_re     = 1'b0;
    b_addr   = {~line, hdump};
    if (busy) begin
      b_we   = 1'b1;
      b_addr = clr_cnt;
    end else begin
      case (state)
        IDLE:    if (pxl_cen && LHBL) begin
                   b_re     = 1'b1;
                   state_nx = READ;
                 end
        READ:    state_nx = ERASE;
        ERASE:   begin
                   b_we     = 1'b1;
                   b_addr   = rd_addr;
                   state_nx = IDLE;
                 end
        default: state_nx = IDLE;
      endcase
    end
    if (rst) begin
      b_we     = 1'b0;
      b_re     = 1'b0;
      state_nx = IDLE;
    end
  end

  // Scan state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Clear sweep: busy rises the cycle after reset release, covers 1024 addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      swept   <= 1'b0;
      clr_cnt <= '0;
    end else if (!swept) begin
      if (!busy) begin
        busy <= 1'b1;
      end else begin
        clr_cnt <= clr_cnt + AW'(1);
        if (clr_cnt == AW'(DEPTH - 1)) begin
          busy  <= 1'b0;
          swept <= 1'b1;
        end
      end
    end
  end

  // Output registers, read address capture and line swap tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pxl_out <= '0;
      pxl_txt <= 1'b0;
      ovr     <= 1'b0;
      line_l  <= line;
      rd_addr <= '0;
    end else begin
      line_l <= line;
      if (line != line_l) begin
        pxl_txt <= txt_line;
        ovr     <= ~done;
      end
      if (busy) begin
        pxl_out <= '0;
      end else if (state == IDLE && pxl_cen) begin
        if (LHBL) rd_addr <= {~line, hdump};
        else      pxl_out <= '0;
      end else if (state == READ) begin
        pxl_out <= q;
      end
    end
  end

  // Dual-port RAM; port A is written last so it wins an address collision
  always_ff @(posedge clk) begin
    if (b_we)   mem[b_addr]    <= CLR_VAL;
    if (scr_we) mem[line_addr] <= line_din;
    if (b_re)   q              <= mem[b_addr];
  end

endmodule

// File: tb/tb_jtcontra_gfx_linebuf.sv
// Randomized self-checking bench for jtcontra_gfx_linebuf against an array model.
module tb_jtcontra_gfx_linebuf;

  logic       clk = 1'b0;
  logic       rst, pxl_cen, LHBL, line, done, txt_line, scr_we;
  logic [8:0] hdump, line_din, pxl_out;
  logic [9:0] line_addr;
  logic       pxl_txt, ovr, busy;

  int total = 0;
  int bad   = 0;
  logic [8:0] mem_m [0:1023];

  always #5 clk = ~clk;

  jtcontra_gfx_linebuf #(.CLR_VAL(9'd0)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .line(line), .done(done), .txt_line(txt_line), .scr_we(scr_we),
    .line_addr(line_addr), .line_din(line_din), .pxl_out(pxl_out),
    .pxl_txt(pxl_txt), .ovr(ovr), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) mem_m[i] = 9'd0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [8:0] d);
    scr_we = 1'b1; line_addr = a; line_din = d;
    tick();
    scr_we = 1'b0;
    mem_m[a] = d;
  endtask

  // One pixel request; checks pxl_out two clocks after pxl_cen
  task automatic do_pxl(input logic [8:0] h, input logic lh, input string nm);
    logic [9:0] a;
    logic [8:0] exp;
    a   = {~line, h};
    exp = lh ? mem_m[a] : 9'd0;
    pxl_cen = 1'b1; hdump = h; LHBL = lh;
    tick();
    pxl_cen = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (pxl_out !== exp) begin
      bad++;
      $display("FAIL %s addr=%h: pxl_out=%h expected=%h", nm, a, pxl_out, exp);
    end
    if (lh) mem_m[a] = 9'd0;
    tick();
  endtask

  task automatic do_swap(input logic d, input logic t);
    line = ~line; done = d; txt_line = t;
    tick();
    @(negedge clk);
    total++;
    if (ovr !== ~d) begin
      bad++;
      $display("FAIL swap_ovr: ovr=%b expected=%b", ovr, ~d);
    end
    total++;
    if (pxl_txt !== t) begin
      bad++;
      $display("FAIL swap_txt: pxl_txt=%b expected=%b", pxl_txt, t);
    end
    tick();
  endtask

  // Counts busy cycles after release; expects exactly 1024
  task automatic wait_sweep(input string nm);
    int n;
    n = 0;
    rst = 1'b0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    total++;
    if (n != 1024) begin
      bad++;
      $display("FAIL %s: busy cycles=%0d expected=1024", nm, n);
    end
    clear_model();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; hdump = '0; line = 1'b0;
    done = 1'b1; txt_line = 1'b0; scr_we = 1'b0; line_addr = '0; line_din = '0;
    tick(); tick(); tick();
    for (int i = 0; i < 16; i++) do_write(10'($urandom), 9'($urandom) | 9'd1);
    @(negedge clk);
    total++;
    if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: busy=%b expected=0", busy); end
    total++;
    if (pxl_out !== 9'd0)  begin bad++; $display("FAIL rst_pxl: pxl_out=%h expected=000", pxl_out); end
    total++;
    if (ovr !== 1'b0)      begin bad++; $display("FAIL rst_ovr: ovr=%b expected=0", ovr); end
    total++;
    if (pxl_txt !== 1'b0)  begin bad++; $display("FAIL rst_txt: pxl_txt=%b expected=0", pxl_txt); end
    tick();
    wait_sweep("sweep_len");
  endtask

  task automatic test_full_clear();
    for (int h = 0; h < 512; h++) do_pxl(9'(h), 1'b1, "clear_half1");
    do_swap(1'b1, 1'b0);
    for (int h = 0; h < 512; h++) do_pxl(9'(h), 1'b1, "clear_half0");
  endtask

  task automatic test_basic();
    if (line) do_swap(1'b1, 1'b0);
    do_write(10'h040, 9'h1A5);
    do_swap(1'b1, 1'b0);
    do_pxl(9'h040, 1'b1, "basic_read");
    do_swap(1'b1, 1'b0);
    do_swap(1'b1, 1'b0);
    do_pxl(9'h040, 1'b1, "basic_reread");
  endtask

  task automatic test_blank();
    logic [8:0] h;
    h = 9'h0AB;
    do_write({~line, h}, 9'h0FF);
    do_pxl(h, 1'b0, "blank_out");
    do_pxl(h, 1'b1, "blank_keep");
  endtask

  task automatic test_overrun();
    do_swap(1'b0, 1'b1);
    do_swap(1'b1, 1'b0);
    do_swap(1'b0, 1'b0);
    do_swap(1'b1, 1'b1);
  endtask

  task automatic test_collision();
    logic [8:0] h;
    logic [9:0] a;
    h = 9'h123;
    a = {~line, h};
    do_write(a, 9'h0C3);
    pxl_cen = 1'b1; hdump = h; LHBL = 1'b1;
    tick();
    pxl_cen = 1'b0;
    tick();
    scr_we = 1'b1; line_addr = a; line_din = 9'h155;
    @(negedge clk);
    total++;
    if (pxl_out !== 9'h0C3) begin bad++; $display("FAIL coll_read: pxl_out=%h expected=0c3", pxl_out); end
    tick();
    scr_we = 1'b0;
    mem_m[a] = 9'h155;
    do_pxl(h, 1'b1, "coll_keep");
  endtask

  task automatic test_back_to_back();
    logic [8:0] h1, h2, v1, v2;
    h1 = 9'h010; h2 = 9'h011;
    v1 = 9'h0A1; v2 = 9'h1B2;
    do_write({~line, h1}, v1);
    do_write({~line, h2}, v2);
    pxl_cen = 1'b1; hdump = h1; LHBL = 1'b1;
    tick();
    pxl_cen = 1'b0;
    tick();
    pxl_cen = 1'b1; hdump = h2;
    @(negedge clk);
    total++;
    if (pxl_out !== v1) begin bad++; $display("FAIL b2b_first: pxl_out=%h expected=%h", pxl_out, v1); end
    tick();
    pxl_cen = 1'b0;
    @(negedge clk);
    total++;
    if (pxl_out !== v1) begin bad++; $display("FAIL b2b_hold: pxl_out=%h expected=%h", pxl_out, v1); end
    tick();
    mem_m[{~line, h1}] = 9'd0;
    do_pxl(h2, 1'b1, "b2b_noerase");
    do_pxl(h1, 1'b1, "b2b_erased");
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)
        do_write({1'($urandom_range(0, 1)), 9'($urandom_range(0, 15))}, 9'($urandom));
      else if (r < 9)
        do_pxl(9'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0), "rand_pxl");
      else
        do_swap(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] h;
    h = 9'h077;
    do_swap(1'b0, 1'b1);
    do_write({~line, h}, 9'h1EE);
    pxl_cen = 1'b1; hdump = h; LHBL = 1'b1;
    tick();
    pxl_cen = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (pxl_out !== 9'd0) begin bad++; $display("FAIL mid_rst_pxl: pxl_out=%h expected=000", pxl_out); end
    total++;
    if (ovr !== 1'b0)     begin bad++; $display("FAIL mid_rst_ovr: ovr=%b expected=0", ovr); end
    total++;
    if (pxl_txt !== 1'b0) begin bad++; $display("FAIL mid_rst_txt: pxl_txt=%b expected=0", pxl_txt); end
    total++;
    if (busy !== 1'b0)    begin bad++; $display("FAIL mid_rst_busy: busy=%b expected=0", busy); end
    tick();
    wait_sweep("resweep_len");
    do_pxl(h, 1'b1, "resweep_clear");
  endtask

  initial begin
    test_reset();
    test_full_clear();
    test_basic();
    test_blank();
    test_overrun();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
